// File: rtl/xkbd_dec_if.sv
// xkbd_dec_if: receiver handshake and CPU-side FIFO signals of the scan-code decoder
interface xkbd_dec_if #(
    parameter int DEPTH_LOG2 = 3
) ();
    logic [8:0]            code_in;
    logic                  ps2_sel;
    logic                  rd;
    logic [18:0]           ev_data;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  ovf;
    logic                  ovf_clr;

    modport master (
        output code_in, rd, ovf_clr,
        input  ps2_sel, ev_data, empty, full, count, ovf
    );

    modport slave (
        input  code_in, rd, ovf_clr,
        output ps2_sel, ev_data, empty, full, count, ovf
    );
endinterface

// File: rtl/xkbd_dec.sv
// xkbd_dec: folds set-2 scan-code bytes into key events with ASCII and queues them in a FIFO
module xkbd_dec #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    xkbd_dec_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    state_t                r_state;
    logic                  r_sel;
    logic [7:0]            r_byte;
    logic                  r_ext;
    logic                  r_brk;
    logic                  r_lshift;
    logic                  r_rshift;

    logic [18:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_ovf;

    logic [7:0]            w_map;
    logic [1:0]            w_kind;
    logic                  w_shift;
    logic [7:0]            w_ascii;
    logic                  w_is_e0;
    logic                  w_is_f0;
    logic                  w_discard;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_ok;
    logic [DEPTH_LOG2:0]   w_count_nx;
    logic [18:0]           w_event;

    // Set-2 code table: kind 1 = letter (lowercase), 2 = digit, 3 = shift-insensitive key
    always_comb begin
        w_map  = 8'h00;
        w_kind = 2'd0;
        case (r_byte)
            8'h1C: begin w_map = 8'h61; w_kind = 2'd1; end
            8'h32: begin w_map = 8'h62; w_kind = 2'd1; end
            8'h21: begin w_map = 8'h63; w_kind = 2'd1; end
            8'h23: begin w_map = 8'h64; w_kind = 2'd1; end
            8'h24: begin w_map = 8'h65; w_kind = 2'd1; end
            8'h2B: begin w_map = 8'h66; w_kind = 2'd1; end
            8'h34: begin w_map = 8'h67; w_kind = 2'd1; end
            8'h33: begin w_map = 8'h68; w_kind = 2'd1; end
            8'h43: begin w_map = 8'h69; w_kind = 2'd1; end
            8'h3B: begin w_map = 8'h6A; w_kind = 2'd1; end
            8'h42: begin w_map = 8'h6B; w_kind = 2'd1; end
            8'h4B: begin w_map = 8'h6C; w_kind = 2'd1; end
            8'h3A: begin w_map = 8'h6D; w_kind = 2'd1; end
            8'h31: begin w_map = 8'h6E; w_kind = 2'd1; end
            8'h44: begin w_map = 8'h6F; w_kind = 2'd1; end
            8'h4D: begin w_map = 8'h70; w_kind = 2'd1; end
            8'h15: begin w_map = 8'h71; w_kind = 2'd1; end
            8'h2D: begin w_map = 8'h72; w_kind = 2'd1; end
            8'h1B: begin w_map = 8'h73; w_kind = 2'd1; end
            8'h2C: begin w_map = 8'h74; w_kind = 2'd1; end
            8'h3C: begin w_map = 8'h75; w_kind = 2'd1; end
            8'h2A: begin w_map = 8'h76; w_kind = 2'd1; end
            8'h1D: begin w_map = 8'h77; w_kind = 2'd1; end
            8'h22: begin w_map = 8'h78; w_kind = 2'd1; end
            8'h35: begin w_map = 8'h79; w_kind = 2'd1; end
            8'h1A: begin w_map = 8'h7A; w_kind = 2'd1; end
            8'h45: begin w_map = 8'h30; w_kind = 2'd2; end
            8'h16: begin w_map = 8'h31; w_kind = 2'd2; end
            8'h1E: begin w_map = 8'h32; w_kind = 2'd2; end
            8'h26: begin w_map = 8'h33; w_kind = 2'd2; end
            8'h25: begin w_map = 8'h34; w_kind = 2'd2; end
            8'h2E: begin w_map = 8'h35; w_kind = 2'd2; end
            8'h36: begin w_map = 8'h36; w_kind = 2'd2; end
            8'h3D: begin w_map = 8'h37; w_kind = 2'd2; end
            8'h3E: begin w_map = 8'h38; w_kind = 2'd2; end
            8'h46: begin w_map = 8'h39; w_kind = 2'd2; end
            8'h29: begin w_map = 8'h20; w_kind = 2'd3; end
            8'h5A: begin w_map = 8'h0D; w_kind = 2'd3; end
            8'h66: begin w_map = 8'h08; w_kind = 2'd3; end
            default: begin w_map = 8'h00; w_kind = 2'd0; end
        endcase
    end

    // Shift level seen by this byte is the state before the byte's own update
    assign w_shift   = r_lshift | r_rshift;
    assign w_ascii   = r_ext             ? 8'h00 :
                       (w_kind == 2'd1)  ? (w_shift ? w_map - 8'h20 : w_map) :
                       (w_kind == 2'd2)  ? (w_shift ? 8'h00 : w_map) :
                       (w_kind == 2'd3)  ? w_map : 8'h00;
    assign w_is_e0   = r_byte == 8'hE0;
    assign w_is_f0   = r_byte == 8'hF0;
    assign w_discard = r_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    assign w_push    = (r_state == ACK) && !w_is_e0 && !w_is_f0 && !w_discard;
    assign w_event   = {r_brk, r_ext, w_shift, r_byte, w_ascii};

    // Popping while full frees the slot the simultaneous push needs
    assign w_pop      = bus.rd && !r_empty;
    assign w_push_ok  = w_push && (!r_full || w_pop);
    assign w_count_nx = r_count + {{DEPTH_LOG2{1'b0}}, w_push_ok} - {{DEPTH_LOG2{1'b0}}, w_pop};

    // Handshake FSM with receiver; decodes the latched byte and tracks prefixes and shift in ACK
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= 1'b0;
            r_byte   <= 8'h00;
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.code_in[8]) begin
                        r_byte  <= bus.code_in[7:0];
                        r_sel   <= 1'b1;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_sel   <= 1'b0;
                    r_state <= WAIT;
                    if (w_is_e0) begin
                        r_ext <= 1'b1;
                    end else if (w_is_f0) begin
                        r_brk <= 1'b1;
                    end else begin
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                        if (!w_discard && !r_ext && r_byte == 8'h12) r_lshift <= !r_brk;
                        if (!w_discard && !r_ext && r_byte == 8'h59) r_rshift <= !r_brk;
                    end
                end
                WAIT: begin
                    if (!bus.code_in[8]) r_state <= IDLE;
                end
                default: begin
                    r_sel   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy flags and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + DEPTH_LOG2'(1);
            if (w_pop) r_rptr <= r_rptr + DEPTH_LOG2'(1);
            r_count <= w_count_nx;
            r_empty <= w_count_nx == '0;
            r_full  <= w_count_nx == (DEPTH_LOG2 + 1)'(DEPTH);
            if (bus.ovf_clr) r_ovf <= 1'b0;
            if (w_push && !w_push_ok) r_ovf <= 1'b1;
        end
    end

    // Event storage; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= w_event;
    end

    assign bus.ps2_sel = r_sel;
    assign bus.ev_data = r_empty ? 19'h0 : r_mem[r_rptr];
    assign bus.empty   = r_empty;
    assign bus.full    = r_full;
    assign bus.count   = r_count;
    assign bus.ovf     = r_ovf;
endmodule
